// File: rtl/switch_allocator_pkg.sv
// Shared NoC router types: port and flit-label encodings plus label helpers.
package noc_params;

    localparam int unsigned PORT_NUM  = 5;
    localparam int unsigned PORT_SIZE = $clog2(PORT_NUM);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL,
        NORTH,
        SOUTH,
        WEST,
        EAST
    } port_t;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_label_t;

    function automatic logic is_head(flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

    function automatic logic is_body_tail(flit_label_t label);
        return (label == BODY) || (label == TAIL);
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Input-port / crossbar side bundle of the switch allocator.
interface switch_allocator_if;
    import noc_params::*;

    logic [PORT_NUM-1:0]                 req_i;
    port_t                               out_port_i   [PORT_NUM];
    flit_label_t                         flit_label_i [PORT_NUM];
    logic [PORT_NUM-1:0]                 credit_i;
    logic [PORT_NUM-1:0]                 grant_o;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0]  xbar_sel_o;
    logic [PORT_NUM-1:0]                 xbar_valid_o;

    modport master (
        output req_i, out_port_i, flit_label_i, credit_i,
        input  grant_o, xbar_sel_o, xbar_valid_o
    );

    modport slave (
        input  req_i, out_port_i, flit_label_i, credit_i,
        output grant_o, xbar_sel_o, xbar_valid_o
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Per-output arbiter: round-robin when SWITCH_ALLOC_RR_EN is defined,
// otherwise fixed priority (lowest index wins, no pointer state).
module round_robin_arbiter
    import noc_params::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PORT_NUM-1:0] req_i,
    input  logic                upd_i,
    output logic [PORT_NUM-1:0] gnt_o
);

`ifdef SWITCH_ALLOC_RR_EN
    logic [PORT_SIZE-1:0] ptr_q, ptr_d;
    logic                 found;

    // Search starts at the pointer; pointer moves past the winner on update.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 0; k < int'(PORT_NUM); k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % int'(PORT_NUM);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                if (upd_i) begin
                    ptr_d = PORT_SIZE'((idx + 1) % int'(PORT_NUM));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic found;
    logic unused_ok;

    assign unused_ok = ^{clk, rst, upd_i};

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < int'(PORT_NUM); k++) begin
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output lock, credit tracking and arbitration.
// Optional round-robin arbitration via SWITCH_ALLOC_RR_EN (fixed priority otherwise).
module switch_allocator
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    switch_allocator_if.slave  sa
);

    localparam int unsigned         CRED_W   = $clog2(BUFFER_SIZE + 1);
    localparam logic [CRED_W-1:0]   CRED_MAX = CRED_W'(BUFFER_SIZE);

    logic [PORT_NUM-1:0]   locked_q, locked_d;
    logic [PORT_SIZE-1:0]  owner_q  [PORT_NUM];
    logic [PORT_SIZE-1:0]  owner_d  [PORT_NUM];
    logic [CRED_W-1:0]     credit_q [PORT_NUM];
    logic [CRED_W-1:0]     credit_d [PORT_NUM];

    logic [PORT_NUM-1:0]   arb_req_c [PORT_NUM];
    logic [PORT_NUM-1:0]   arb_gnt_c [PORT_NUM];
    logic [PORT_NUM-1:0]   arb_upd_c;
    logic [PORT_NUM-1:0]   out_gnt_c;
    logic [PORT_SIZE-1:0]  out_src_c [PORT_NUM];

    // Head-flit candidates per output; only idle outputs with credit arbitrate.
    always_comb begin
        for (int o = 0; o < int'(PORT_NUM); o++) begin
            arb_req_c[o] = '0;
            for (int i = 0; i < int'(PORT_NUM); i++) begin
                if (sa.req_i[i] && (sa.out_port_i[i] == PORT_SIZE'(o))
                    && is_head(sa.flit_label_i[i])) begin
                    arb_req_c[o][i] = 1'b1;
                end
            end
            if (locked_q[o] || (credit_q[o] == '0)) begin
                arb_req_c[o] = '0;
            end
        end
    end

    for (genvar g = 0; g < int'(PORT_NUM); g++) begin : g_arb
        round_robin_arbiter u_arb (
            .clk   (clk),
            .rst   (rst),
            .req_i (arb_req_c[g]),
            .upd_i (arb_upd_c[g]),
            .gnt_o (arb_gnt_c[g])
        );
    end

    // Allocation: locked outputs serve only their owner's BODY/TAIL flits.
    always_comb begin
        out_gnt_c = '0;
        arb_upd_c = '0;
        for (int o = 0; o < int'(PORT_NUM); o++) begin
            out_src_c[o] = '0;
            if (locked_q[o]) begin
                if (sa.req_i[owner_q[o]]
                    && (sa.out_port_i[owner_q[o]] == PORT_SIZE'(o))
                    && is_body_tail(sa.flit_label_i[owner_q[o]])
                    && (credit_q[o] != '0)) begin
                    out_gnt_c[o] = 1'b1;
                    out_src_c[o] = owner_q[o];
                end
            end else begin
                for (int i = 0; i < int'(PORT_NUM); i++) begin
                    if (arb_gnt_c[o][i]) begin
                        out_gnt_c[o] = 1'b1;
                        out_src_c[o] = PORT_SIZE'(i);
                        arb_upd_c[o] = 1'b1;
                    end
                end
            end
        end
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        sa.grant_o      = '0;
        sa.xbar_sel_o   = '0;
        sa.xbar_valid_o = '0;
        if (!rst) begin
            for (int o = 0; o < int'(PORT_NUM); o++) begin
                if (out_gnt_c[o]) begin
                    sa.grant_o[out_src_c[o]] = 1'b1;
                    sa.xbar_sel_o[o]         = out_src_c[o];
                    sa.xbar_valid_o[o]       = 1'b1;
                end
            end
        end
    end

    // Lock and credit next state.
    always_comb begin
        locked_d = locked_q;
        for (int o = 0; o < int'(PORT_NUM); o++) begin
            owner_d[o]  = owner_q[o];
            credit_d[o] = credit_q[o];
            if (out_gnt_c[o]) begin
                if (!locked_q[o] && (sa.flit_label_i[out_src_c[o]] == HEAD)) begin
                    locked_d[o] = 1'b1;
                    owner_d[o]  = out_src_c[o];
                end else if (locked_q[o] && (sa.flit_label_i[out_src_c[o]] == TAIL)) begin
                    locked_d[o] = 1'b0;
                end
            end
            case ({out_gnt_c[o], sa.credit_i[o]})
                2'b10:   credit_d[o] = credit_q[o] - CRED_W'(1);
                2'b01:   credit_d[o] = (credit_q[o] == CRED_MAX) ? CRED_MAX
                                                                 : credit_q[o] + CRED_W'(1);
                default: credit_d[o] = credit_q[o];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_q <= '0;
            for (int o = 0; o < int'(PORT_NUM); o++) begin
                owner_q[o]  <= '0;
                credit_q[o] <= CRED_MAX;
            end
        end else begin
            locked_q <= locked_d;
            for (int o = 0; o < int'(PORT_NUM); o++) begin
                owner_q[o]  <= owner_d[o];
                credit_q[o] <= credit_d[o];
            end
        end
    end

    // Protocol checks: credit overflow, stray BODY/TAIL, HEAD from a locked owner.
    always @(posedge clk) begin
        if (!rst) begin
            for (int o = 0; o < int'(PORT_NUM); o++) begin
                assert (!(sa.credit_i[o] && !out_gnt_c[o] && (credit_q[o] == CRED_MAX)))
                    else $warning("switch_allocator: credit overflow on output %0d", o);
            end
            for (int i = 0; i < int'(PORT_NUM); i++) begin
                if (sa.req_i[i]) begin
                    assert (!(!locked_q[sa.out_port_i[i]] && is_body_tail(sa.flit_label_i[i])))
                        else $warning("switch_allocator: BODY/TAIL from input %0d to idle output", i);
                    assert (!(locked_q[sa.out_port_i[i]]
                              && (owner_q[sa.out_port_i[i]] == PORT_SIZE'(i))
                              && is_head(sa.flit_label_i[i])))
                        else $warning("switch_allocator: HEAD from owner input %0d while locked", i);
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, arbitration, wormhole lock, credits.
module tb_switch_allocator;
    import noc_params::*;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    switch_allocator_if sa_if ();

    switch_allocator #(.BUFFER_SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .sa  (sa_if)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(string tag, logic [4:0] g, logic [4:0] v);
        check({tag, "_grant"}, {11'd0, sa_if.grant_o}, {11'd0, g});
        check({tag, "_valid"}, {11'd0, sa_if.xbar_valid_o}, {11'd0, v});
    endtask

    function automatic logic [14:0] sel_at(int o, int i);
        logic [14:0] r;
        r = '0;
        r[o*3 +: 3] = 3'(i);
        return r;
    endfunction

    task automatic clear_inputs();
        sa_if.req_i    = '0;
        sa_if.credit_i = '0;
        for (int i = 0; i < int'(PORT_NUM); i++) begin
            sa_if.out_port_i[i]   = LOCAL;
            sa_if.flit_label_i[i] = HEAD;
        end
    endtask

    task automatic drive(int i, port_t p, flit_label_t l);
        sa_if.req_i[i]        = 1'b1;
        sa_if.out_port_i[i]   = p;
        sa_if.flit_label_i[i] = l;
    endtask

    logic [4:0] exp_g [5];
    int         n_cont;

    initial begin
        // Reset holds every output low even with a live request.
        rst = 1'b1;
        clear_inputs();
        drive(1, EAST, HEADTAIL);
        #2;
        check_out("rst", 5'b00000, 5'b00000);
        check("rst_sel", {1'b0, sa_if.xbar_sel_o}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_out("ht_1to4", 5'b00010, 5'b10000);
        check("ht_sel", {1'b0, sa_if.xbar_sel_o}, {1'b0, sel_at(4, 1)});
        @(negedge clk);
        clear_inputs();
        drive(0, EAST, HEADTAIL);
        #2;
        check_out("ht_still_idle", 5'b00001, 5'b10000);
        @(negedge clk);

        // Contention on output 1.
        clear_inputs();
        drive(0, NORTH, HEADTAIL);
        drive(2, NORTH, HEADTAIL);
        drive(3, NORTH, HEADTAIL);
`ifdef SWITCH_ALLOC_RR_EN
        exp_g[0] = 5'b00001; exp_g[1] = 5'b00100; exp_g[2] = 5'b01000;
        exp_g[3] = 5'b00001; exp_g[4] = 5'b00100;
        n_cont = 5;
`else
        exp_g[0] = 5'b00001; exp_g[1] = 5'b00001; exp_g[2] = 5'b00001;
        exp_g[3] = 5'b00001; exp_g[4] = 5'b00001;
        n_cont = 3;
`endif
        for (int k = 0; k < n_cont; k++) begin
            #2;
            check_out($sformatf("contend_%0d", k), exp_g[k], 5'b00010);
            @(negedge clk);
        end

        // Wormhole: input 2 owns output 0 for HEAD/BODY/TAIL, input 3 waits.
        clear_inputs();
        drive(2, LOCAL, HEAD);
        drive(3, LOCAL, HEAD);
        #2;
        check_out("wh_c0", 5'b00100, 5'b00001);
        @(negedge clk);
        drive(2, LOCAL, BODY);
        #2;
        check_out("wh_c1", 5'b00100, 5'b00001);
        @(negedge clk);
        drive(2, LOCAL, TAIL);
        #2;
        check_out("wh_c2", 5'b00100, 5'b00001);
        @(negedge clk);
        sa_if.req_i[2] = 1'b0;
        #2;
        check_out("wh_c3", 5'b01000, 5'b00001);
        check("wh_c3_sel", {1'b0, sa_if.xbar_sel_o}, {1'b0, sel_at(0, 3)});
        @(negedge clk);
        drive(2, LOCAL, HEAD);
        drive(3, LOCAL, BODY);
        #2;
        check_out("wh_lock3_body", 5'b01000, 5'b00001);
        @(negedge clk);
        drive(3, LOCAL, TAIL);
        #2;
        check_out("wh_lock3_tail", 5'b01000, 5'b00001);
        @(negedge clk);
        sa_if.req_i[3] = 1'b0;
        #2;
        check_out("wh_relock2", 5'b00100, 5'b00001);
        @(negedge clk);

        // Reset in the middle of a packet drops the lock at once.
        drive(2, LOCAL, BODY);
        #2;
        check_out("mp_before", 5'b00100, 5'b00001);
        rst = 1'b1;
        #1;
        check_out("mp_in_rst", 5'b00000, 5'b00000);
        check("mp_in_rst_sel", {1'b0, sa_if.xbar_sel_o}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        drive(3, LOCAL, HEAD);
        #2;
        check_out("mp_after", 5'b01000, 5'b00001);
        @(negedge clk);

        // Credits on output 2: eight grants then stall.
        clear_inputs();
        drive(0, SOUTH, HEADTAIL);
        for (int k = 0; k < 8; k++) begin
            #2;
            check_out($sformatf("cr_grant_%0d", k), 5'b00001, 5'b00100);
            @(negedge clk);
        end
        #2;
        check_out("cr_stall", 5'b00000, 5'b00000);
        sa_if.credit_i[2] = 1'b1;
        @(negedge clk);
        sa_if.credit_i[2] = 1'b0;
        #2;
        check_out("cr_return", 5'b00001, 5'b00100);
        @(negedge clk);
        #2;
        check_out("cr_empty", 5'b00000, 5'b00000);
        sa_if.credit_i[2] = 1'b1;
        @(negedge clk);
        #2;
        check_out("cr_both", 5'b00001, 5'b00100);
        @(negedge clk);
        sa_if.credit_i[2] = 1'b0;
        #2;
        check_out("cr_kept", 5'b00001, 5'b00100);
        @(negedge clk);
        #2;
        check_out("cr_drained", 5'b00000, 5'b00000);
        @(negedge clk);

        // Protocol errors: BODY to idle output, credit into a full counter.
        clear_inputs();
        drive(4, WEST, BODY);
        #2;
        check_out("pe_body_c0", 5'b00000, 5'b00000);
        @(negedge clk);
        #2;
        check_out("pe_body_c1", 5'b00000, 5'b00000);
        @(negedge clk);
        clear_inputs();
        sa_if.credit_i[3] = 1'b1;
        #2;
        @(negedge clk);
        sa_if.credit_i[3] = 1'b0;
        drive(4, WEST, HEADTAIL);
        for (int k = 0; k < 8; k++) begin
            #2;
            check_out($sformatf("sat_grant_%0d", k), 5'b10000, 5'b01000);
            @(negedge clk);
        end
        #2;
        check_out("sat_stall", 5'b00000, 5'b00000);
        @(negedge clk);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
